layer_weight_update: RTL and testbench
======================================

# layer_weight_update

Backward-direction counterpart to the forward propagation datapath: one gradient-descent update of one dense layer. It captures a layer's weights, biases, output error term (delta) and input activations, then walks the weight matrix one element per cycle. Each step applies W <= W - lr·delta·aᵀ and b <= b - lr·delta, with lr = 2^-LR_SHIFT. It sits after the forward net's output registers and feeds updated W/b back to the forward net's input registers.

## Interface
- M, 2, layer output count (rows of W, length of delta and b)
- N, 3, layer input count (columns of W, length of a_prev)
- DW, 16, signed fixed-point word width (matches data_type)
- FRAC, 8, fractional bits of every DW word
- LR_SHIFT, 2, learning rate as right shift (lr = 2^-LR_SHIFT)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request an update; sampled only in IDLE
- hold  in  1  freezes the UPDATE walk while high
- W_in  in  [M][N]×DW  weights to update
- b_in  in  [M]×DW  biases to update
- delta  in  [M]×DW  output error term
- a_prev  in  [N]×DW  layer input activations
- W_out  out  [M][N]×DW  working/updated weights
- b_out  out  [M]×DW  working/updated biases
- busy  out  1  high in LOAD and UPDATE
- done  out  1  one-cycle pulse when update completes

## Operation
- FSM states: IDLE, LOAD, UPDATE, DONE.
- IDLE: when start=1, go to LOAD. Otherwise stay in IDLE.
- LOAD: one cycle. Registers W_in, b_in, delta and a_prev internally, and clears the row index i and column index j to 0. Then goes to UPDATE.
- UPDATE: on each cycle with hold=0:
  - Full-precision signed product p = delta[i]·a_prev[j] (2·DW bits).
  - Arithmetic right shift (floor) by FRAC+LR_SHIFT.
  - W[i][j] <= W[i][j] - shifted p.
  - When j = N-1, in the same cycle: b[i] <= b[i] - (delta[i] >>> LR_SHIFT).
  - Index order is row-major: j increments; at j = N-1, j wraps to 0 and i increments.
  - After element (M-1, N-1), go to DONE.
- hold=1 in UPDATE: indices and registers are unchanged.
- DONE: done=1 for one cycle, then go to IDLE.
- W_out and b_out are the internal registers, so partial updates are visible during UPDATE. After done they hold the final values until the next LOAD.
- start is ignored in LOAD, UPDATE and DONE. Captured inputs are not affected by later input changes.
- Subtraction is computed at DW+DW+1 bits. It is then saturated or wrapped to DW bits, per Configuration.

## Timing
- Reset (asynchronous, on reset=0): FSM to IDLE, i=j=0, W_out=0, b_out=0, busy=0, done=0. Takes effect immediately in any state; any in-progress update is abandoned.
- start sampled at edge 0 → LOAD during cycle 1 → UPDATE for M·N cycles with hold=0 → done=1 in cycle M·N+2.
- Total latency from start edge to done: M·N+2 cycles, plus one cycle per cycle of hold=1 during UPDATE.
- busy rises the cycle after start is sampled and falls when done rises.
- The earliest back-to-back start is sampled in the IDLE cycle after done.

## Configuration
- WEIGHT_UPDATE_SATURATE_EN defined: W and b results clamp to [-2^(DW-1), 2^(DW-1)-1].
- WEIGHT_UPDATE_SATURATE_EN undefined: results take the low DW bits (two's-complement wrap).

## Test plan
All scenarios use M=2, N=3, DW=16, FRAC=8, LR_SHIFT=2.
- Basic update:
  - Stimulus: W=0, b=0, delta=[256,0], a_prev=[256,512,-256], start pulse.
  - Response: W[0]=[-64,-128,64], W[1]=[0,0,0], b=[-64,0]; done exactly 8 cycles after the start edge.
- Saturation/wrap:
  - Stimulus: W[0][0]=-32700, delta[0]=32767, a_prev[0]=32767.
  - Response: W[0][0]=-32768 with the macro defined; -32636 without it.
- Hold:
  - Stimulus: basic case with hold=1 for 3 cycles in the middle of UPDATE.
  - Response: same final values; done at 11 cycles; W_out unchanged during hold.
- Start while busy:
  - Stimulus: second start with different inputs during UPDATE.
  - Response: ignored; results equal the first update; exactly one done pulse.
- Reset mid-operation:
  - Stimulus: reset=0 asynchronously in the 4th UPDATE cycle.
  - Response: W_out, b_out, busy and done are 0 immediately. A fresh start after release gives the basic-update results.
- Floor rounding:
  - Stimulus: delta[0]=-1, a_prev[0]=1, W=0.
  - Response: W[0][0]=+1 (floor of -1/1024 is -1); b[0]=+1.

Source files
------------

// File: rtl/layer_weight_update.sv
// layer_weight_update
// One gradient-descent step for a dense layer with M outputs and N inputs:
//   W[i][j] <= W[i][j] - ((delta[i] * a_prev[j]) >>> (FRAC + LR_SHIFT))
//   b[i]    <= b[i]    - (delta[i] >>> LR_SHIFT)      (applied on the last column)
// The layer operands are captured in one LOAD cycle. The matrix is then walked
// in row-major order, one element per cycle, and the walk pauses while hold is high.
//
// Build option:
//   WEIGHT_UPDATE_SATURATE_EN  defined   -> W/b results clamp to the DW-bit signed range
//                              undefined -> W/b results wrap (low DW bits kept)
module layer_weight_update #(
    parameter int M        = 2,
    parameter int N        = 3,
    parameter int DW       = 16,
    parameter int FRAC     = 8,
    parameter int LR_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         hold,
    input  logic [M-1:0][N-1:0][DW-1:0]  W_in,
    input  logic [M-1:0][DW-1:0]         b_in,
    input  logic [M-1:0][DW-1:0]         delta,
    input  logic [N-1:0][DW-1:0]         a_prev,
    output logic [M-1:0][N-1:0][DW-1:0]  W_out,
    output logic [M-1:0][DW-1:0]         b_out,
    output logic                         busy,
    output logic                         done
);

    // Index widths are at least one bit so that degenerate 1-row/1-column layers still elaborate.
    localparam int IW    = (M > 1) ? $clog2(M) : 1;
    localparam int JW    = (N > 1) ? $clog2(N) : 1;
    localparam int SHIFT = FRAC + LR_SHIFT;

    localparam logic [IW-1:0] I_LAST = IW'(M - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reduce a (2*DW+1)-bit signed difference to a DW-bit word: clamp or wrap.
    function automatic logic [DW-1:0] fit_word(input logic [2*DW:0] x);
        logic [DW-1:0] r;
`ifdef WEIGHT_UPDATE_SATURATE_EN
        // The value fits when every bit above the DW-bit sign position equals that sign bit.
        if (x[2*DW:DW-1] == {(DW+2){x[DW-1]}}) begin
            r = x[DW-1:0];
        end else if (x[2*DW] == 1'b1) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
`else
        r = x[DW-1:0];
`endif
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State, indices and working copies of the layer
    // ---------------------------------------------------------------------
    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [IW-1:0]                 i_r;
    logic [JW-1:0]                 j_r;
    logic [M-1:0][N-1:0][DW-1:0]   w_r;
    logic [M-1:0][DW-1:0]          b_r;
    logic [M-1:0][DW-1:0]          delta_r;
    logic [N-1:0][DW-1:0]          a_r;
    logic                          busy_r;
    logic                          done_r;

    // FSM decode
    logic                          load_s;
    logic                          step_s;
    logic                          row_end_s;
    logic                          last_s;

    // Element datapath
    logic signed [DW-1:0]          delta_cur_s;
    logic signed [DW-1:0]          a_cur_s;
    logic signed [DW-1:0]          w_cur_s;
    logic signed [DW-1:0]          b_cur_s;
    logic signed [DW-1:0]          db_s;
    logic signed [2*DW-1:0]        prod_s;
    logic signed [2*DW-1:0]        dw_s;
    logic signed [2*DW:0]          w_diff_s;
    logic signed [2*DW:0]          b_diff_s;
    logic [DW-1:0]                 w_new_s;
    logic [DW-1:0]                 b_new_s;

    // Next-state logic and per-cycle control strobes for the update walk.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        row_end_s   = (j_r == J_LAST);
        last_s      = row_end_s && (i_r == I_LAST);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                load_s      = 1'b1;
                state_nxt_s = UPDATE;
            end
            UPDATE: begin
                if (!hold) begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = UPDATE;
                    end
                end else begin
                    state_nxt_s = UPDATE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Element update math: full-precision product, floor shift, wide subtract, then fit to DW.
    always_comb begin
        delta_cur_s = $signed(delta_r[i_r]);
        a_cur_s     = $signed(a_r[j_r]);
        w_cur_s     = $signed(w_r[i_r][j_r]);
        b_cur_s     = $signed(b_r[i_r]);
        // Operands are sign-extended to the product width so the multiply is exact.
        prod_s      = $signed({{DW{delta_cur_s[DW-1]}}, delta_cur_s})
                    * $signed({{DW{a_cur_s[DW-1]}}, a_cur_s});
        // Arithmetic shift floors toward minus infinity (e.g. -1/1024 becomes -1).
        dw_s        = prod_s >>> SHIFT;
        db_s        = delta_cur_s >>> LR_SHIFT;
        w_diff_s    = {{(DW+1){w_cur_s[DW-1]}}, w_cur_s} - {dw_s[2*DW-1], dw_s};
        b_diff_s    = {{(DW+1){b_cur_s[DW-1]}}, b_cur_s} - {{(DW+1){db_s[DW-1]}}, db_s};
        w_new_s     = fit_word(w_diff_s);
        b_new_s     = fit_word(b_diff_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered status flags, derived from the state being entered so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == LOAD) || (state_nxt_s == UPDATE);
            done_r <= (state_nxt_s == DONE);
        end
    end

    // Operand capture on LOAD and one element (plus the row bias on the last column) per step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_r     <= '0;
            j_r     <= '0;
            w_r     <= '0;
            b_r     <= '0;
            delta_r <= '0;
            a_r     <= '0;
        end else if (load_s) begin
            i_r     <= '0;
            j_r     <= '0;
            w_r     <= W_in;
            b_r     <= b_in;
            delta_r <= delta;
            a_r     <= a_prev;
        end else if (step_s) begin
            w_r[i_r][j_r] <= w_new_s;
            if (row_end_s) begin
                b_r[i_r] <= b_new_s;
                j_r      <= '0;
                if (last_s) begin
                    i_r <= '0;
                end else begin
                    i_r <= i_r + IW'(1);
                end
            end else begin
                j_r <= j_r + JW'(1);
            end
        end else begin
            i_r <= i_r;
            j_r <= j_r;
        end
    end

    assign W_out = w_r;
    assign b_out = b_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_layer_weight_update.sv
// Directed testbench for layer_weight_update (M=2, N=3, DW=16, FRAC=8, LR_SHIFT=2).
module tb_layer_weight_update;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int VW = M * N * DW;

    logic                         clk;
    logic                         reset;
    logic                         start;
    logic                         hold;
    logic [M-1:0][N-1:0][DW-1:0]  W_in;
    logic [M-1:0][DW-1:0]         b_in;
    logic [M-1:0][DW-1:0]         delta;
    logic [N-1:0][DW-1:0]         a_prev;
    logic [M-1:0][N-1:0][DW-1:0]  W_out;
    logic [M-1:0][DW-1:0]         b_out;
    logic                         busy;
    logic                         done;

    int n_cmp  = 0;
    int n_fail = 0;

    layer_weight_update #(
        .M(2), .N(3), .DW(16), .FRAC(8), .LR_SHIFT(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .hold   (hold),
        .W_in   (W_in),
        .b_in   (b_in),
        .delta  (delta),
        .a_prev (a_prev),
        .W_out  (W_out),
        .b_out  (b_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [VW-1:0] obs,
                       input logic signed [VW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_basic();
        W_in      = '0;
        b_in      = '0;
        delta     = '0;
        a_prev    = '0;
        delta[0]  = 16'sd256;
        a_prev[0] = 16'sd256;
        a_prev[1] = 16'sd512;
        a_prev[2] = -16'sd256;
    endtask

    // Start is raised before an edge, sampled by it, and dropped #1 later (cycle 1 = LOAD).
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycle c is the interval after the c-th edge, counting the start-sampling edge as 1.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (done !== 1'b1 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic chk_basic(input string p);
        chk({p, "_w00"}, $signed(W_out[0][0]), -64);
        chk({p, "_w01"}, $signed(W_out[0][1]), -128);
        chk({p, "_w02"}, $signed(W_out[0][2]), 64);
        chk({p, "_w1row"}, W_out[1], 0);
        chk({p, "_b0"}, $signed(b_out[0]), -64);
        chk({p, "_b1"}, $signed(b_out[1]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ndone;
        int sat_exp;
`ifdef WEIGHT_UPDATE_SATURATE_EN
        sat_exp = -32768;
`else
        sat_exp = -32636;
`endif
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        set_basic();

        // Reset state
        #12;
        chk("rst_w", W_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic update
        set_basic();
        do_start();
        chk("basic_busy", busy, 1);
        chk("basic_done_early", done, 0);
        wait_done(1, c);
        chk("basic_latency", c, 8);
        chk("basic_done", done, 1);
        chk("basic_busy_at_done", busy, 0);
        chk_basic("basic");
        @(posedge clk);
        #1;
        chk("basic_done_pulse", done, 0);
        chk_basic("basic_held");

        // Saturation / wrap
        W_in      = '0;
        b_in      = '0;
        delta     = '0;
        a_prev    = '0;
        W_in[0][0] = -16'sd32700;
        delta[0]   = 16'sd32767;
        a_prev[0]  = 16'sd32767;
        do_start();
        wait_done(1, c);
        chk("sat_latency", c, 8);
        chk("sat_w00", $signed(W_out[0][0]), sat_exp);
        chk("sat_w01", $signed(W_out[0][1]), 0);
        chk("sat_b0", $signed(b_out[0]), -8191);
        @(posedge clk);
        #1;

        // Floor rounding of negative products
        W_in      = '0;
        b_in      = '0;
        delta     = '0;
        a_prev    = '0;
        delta[0]  = -16'sd1;
        a_prev[0] = 16'sd1;
        do_start();
        wait_done(1, c);
        chk("floor_w00", $signed(W_out[0][0]), 1);
        chk("floor_w01", $signed(W_out[0][1]), 0);
        chk("floor_b0", $signed(b_out[0]), 1);
        @(posedge clk);
        #1;

        // Hold for three cycles after the first element has been written
        set_basic();
        do_start();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("hold_pre_w00", $signed(W_out[0][0]), -64);
        hold = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("hold_w00", $signed(W_out[0][0]), -64);
        chk("hold_w01", $signed(W_out[0][1]), 0);
        chk("hold_busy", busy, 1);
        hold = 1'b0;
        wait_done(6, c);
        chk("hold_latency", c, 11);
        chk_basic("hold");
        @(posedge clk);
        #1;

        // Second start with different inputs during UPDATE is ignored
        set_basic();
        do_start();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        W_in      = {M*N{16'sd100}};
        b_in      = {M{16'sd50}};
        delta[0]  = 16'sd512;
        delta[1]  = 16'sd1024;
        a_prev[0] = 16'sd1024;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(4, c);
        chk("busy_latency", c, 8);
        chk_basic("busy");
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("busy_extra_done", ndone, 0);
        chk("busy_idle", busy, 0);

        // Asynchronous reset during the 4th UPDATE cycle
        set_basic();
        do_start();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid_pre_w00", $signed(W_out[0][0]), -64);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_w", W_out, 0);
        chk("rstmid_b", b_out, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        set_basic();
        do_start();
        wait_done(1, c);
        chk("rerun_latency", c, 8);
        chk_basic("rerun");
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
